// File: rtl/ntt_bitrev_bram.sv
// ntt_bitrev_bram
// In-place bit-reversal permutation of NUM_BATCH contiguous batches of
// 2^LOG_N words held in a single-port BRAM. It shares the BRAM port with the
// NTT core, so the PS can load coefficients in natural order.
//
// Optional feature: define NTT_BITREV_CYCLE_CNT_EN to add the cycle_cnt[31:0]
// output. It counts busy cycles of the last run and saturates at 2^32-1.
//
// Ports:
//   clk        single clock
//   rst        asynchronous reset, active low
//   start      one-cycle request, accepted only in IDLE
//   busy       high while permuting
//   done       one-cycle pulse at completion
//   err        sticky, set by a start that arrives while not IDLE
//   BRAM_*     BRAM port: addr/clk/din/dout/en/rst/we
//   cycle_cnt  busy-cycle counter (only with NTT_BITREV_CYCLE_CNT_EN)
//
// Handshake: start is a level sampled on the rising clock edge. In IDLE it
// starts a run. In any other state it is ignored and sets err. done is high
// for exactly one cycle (the FIN state). busy is high from the first SCAN
// cycle through the last WR_J/SCAN cycle.
module ntt_bitrev_bram #(
   parameter int DATA_W    = 64,
   parameter int ADDR_W    = 10,
   parameter int LOG_N     = 10,
   parameter int NUM_BATCH = 1,
   parameter int RD_LAT    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              err,
`ifdef NTT_BITREV_CYCLE_CNT_EN
   output logic [31:0]       cycle_cnt,
`endif
   output logic [ADDR_W-1:0] BRAM_addr,
   output logic              BRAM_clk,
   output logic [DATA_W-1:0] BRAM_din,
   input  logic [DATA_W-1:0] BRAM_dout,
   output logic              BRAM_en,
   output logic              BRAM_rst,
   output logic              BRAM_we
);

   typedef enum logic [2:0] {
      IDLE, SCAN, RD_I, RD_J, WAIT, WR_I, WR_J, FIN
   } state_t;

   localparam logic [LOG_N-1:0]  I_LAST = '1;
   localparam logic [ADDR_W-1:0] B_LAST = ADDR_W'(NUM_BATCH - 1);

   state_t              state_q, state_d;
   logic [LOG_N-1:0]    i_q, i_d;
   logic [ADDR_W-1:0]   b_q, b_d;
   logic [1:0]          wcnt_q, wcnt_d;
   logic [DATA_W-1:0]   d_i_q, d_i_d, d_j_q, d_j_d;
   logic                err_q, err_d;
   // Read tag pipeline. tv marks a read in flight; tw says it targets j.
   logic [RD_LAT-1:0]   tv_q, tv_d, tw_q, tw_d;

   logic [LOG_N-1:0]    j;
   logic [ADDR_W-1:0]   base, addr_i, addr_j;

   always_comb begin
      j = '0;
      for (int k = 0; k < LOG_N; k++) j[k] = i_q[LOG_N-1-k];
   end

   assign base   = b_q << LOG_N;
   assign addr_i = base + ADDR_W'(i_q);
   assign addr_j = base + ADDR_W'(j);

   assign BRAM_clk = clk;
   assign BRAM_rst = !rst;
   assign busy     = (state_q != IDLE) && (state_q != FIN);
   assign done     = (state_q == FIN);
   assign err      = err_q;

   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      b_d       = b_q;
      wcnt_d    = wcnt_q;
      err_d     = err_q;
      BRAM_en   = 1'b0;
      BRAM_we   = 1'b0;
      BRAM_addr = '0;
      BRAM_din  = '0;

      if (start && state_q != IDLE) err_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (start) begin
               err_d   = 1'b0;
               b_d     = '0;
               i_d     = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (i_q < j) begin
               state_d = RD_I;
            end else if (i_q == I_LAST) begin
               if (b_q == B_LAST) begin
                  state_d = FIN;
               end else begin
                  b_d = b_q + 1'b1;
                  i_d = '0;
               end
            end else begin
               i_d = i_q + 1'b1;
            end
         end
         RD_I: begin
            BRAM_en   = 1'b1;
            BRAM_addr = addr_i;
            state_d   = RD_J;
         end
         RD_J: begin
            BRAM_en   = 1'b1;
            BRAM_addr = addr_j;
            wcnt_d    = '0;
            state_d   = WAIT;
         end
         WAIT: begin
            // RD_LAT cycles give the j read time to land in d_j.
            if (wcnt_q == 2'(RD_LAT - 1)) state_d = WR_I;
            else wcnt_d = wcnt_q + 1'b1;
         end
         WR_I: begin
            BRAM_en   = 1'b1;
            BRAM_we   = 1'b1;
            BRAM_addr = addr_i;
            BRAM_din  = d_j_q;
            state_d   = WR_J;
         end
         WR_J: begin
            BRAM_en   = 1'b1;
            BRAM_we   = 1'b1;
            BRAM_addr = addr_j;
            BRAM_din  = d_i_q;
            state_d   = SCAN;
            if (i_q == I_LAST) begin
               if (b_q == B_LAST) begin
                  state_d = FIN;
               end else begin
                  b_d = b_q + 1'b1;
                  i_d = '0;
               end
            end else begin
               i_d = i_q + 1'b1;
            end
         end
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tv_d    = '0;
      tw_d    = '0;
      tv_d[0] = (state_q == RD_I) || (state_q == RD_J);
      tw_d[0] = (state_q == RD_J);
      for (int k = 1; k < RD_LAT; k++) begin
         tv_d[k] = tv_q[k-1];
         tw_d[k] = tw_q[k-1];
      end
      d_i_d = d_i_q;
      d_j_d = d_j_q;
      if (tv_q[RD_LAT-1]) begin
         if (tw_q[RD_LAT-1]) d_j_d = BRAM_dout;
         else d_i_d = BRAM_dout;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         i_q     <= '0;
         b_q     <= '0;
         wcnt_q  <= '0;
         d_i_q   <= '0;
         d_j_q   <= '0;
         err_q   <= 1'b0;
         tv_q    <= '0;
         tw_q    <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         b_q     <= b_d;
         wcnt_q  <= wcnt_d;
         d_i_q   <= d_i_d;
         d_j_q   <= d_j_d;
         err_q   <= err_d;
         tv_q    <= tv_d;
         tw_q    <= tw_d;
      end
   end

`ifdef NTT_BITREV_CYCLE_CNT_EN
   logic [31:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE && start) cnt_d = '0;
      else if (busy && cnt_q != '1) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end

   assign cycle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_ntt_bitrev_bram.sv
module tb_ntt_bitrev_bram;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   // Instance 0: LOG_N=3, RD_LAT=1, NUM_BATCH=1
   // Instance 1: LOG_N=3, RD_LAT=1, NUM_BATCH=2
   // Instance 2: LOG_N=3, RD_LAT=2, NUM_BATCH=1
   // Instance 3: LOG_N=1, RD_LAT=1, NUM_BATCH=1
   logic [3:0]  start_v;
   logic        busy_v [4];
   logic        done_v [4];
   logic        err_v  [4];
   logic        en_v   [4];
   logic        we_v   [4];
   logic        bclk_v [4];
   logic        brst_v [4];
   logic [4:0]  addr_v [4];
   logic [15:0] din_v  [4];
   logic [15:0] dout_v [4];
   logic [31:0] cc_v   [4];

   ntt_bitrev_bram #(.DATA_W(16), .ADDR_W(5), .LOG_N(3), .NUM_BATCH(1), .RD_LAT(1)) u0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]),
`ifdef NTT_BITREV_CYCLE_CNT_EN
      .cycle_cnt(cc_v[0]),
`endif
      .BRAM_addr(addr_v[0]), .BRAM_clk(bclk_v[0]), .BRAM_din(din_v[0]), .BRAM_dout(dout_v[0]),
      .BRAM_en(en_v[0]), .BRAM_rst(brst_v[0]), .BRAM_we(we_v[0]));

   ntt_bitrev_bram #(.DATA_W(16), .ADDR_W(5), .LOG_N(3), .NUM_BATCH(2), .RD_LAT(1)) u1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]),
`ifdef NTT_BITREV_CYCLE_CNT_EN
      .cycle_cnt(cc_v[1]),
`endif
      .BRAM_addr(addr_v[1]), .BRAM_clk(bclk_v[1]), .BRAM_din(din_v[1]), .BRAM_dout(dout_v[1]),
      .BRAM_en(en_v[1]), .BRAM_rst(brst_v[1]), .BRAM_we(we_v[1]));

   ntt_bitrev_bram #(.DATA_W(16), .ADDR_W(5), .LOG_N(3), .NUM_BATCH(1), .RD_LAT(2)) u2 (
      .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]), .err(err_v[2]),
`ifdef NTT_BITREV_CYCLE_CNT_EN
      .cycle_cnt(cc_v[2]),
`endif
      .BRAM_addr(addr_v[2]), .BRAM_clk(bclk_v[2]), .BRAM_din(din_v[2]), .BRAM_dout(dout_v[2]),
      .BRAM_en(en_v[2]), .BRAM_rst(brst_v[2]), .BRAM_we(we_v[2]));

   ntt_bitrev_bram #(.DATA_W(16), .ADDR_W(5), .LOG_N(1), .NUM_BATCH(1), .RD_LAT(1)) u3 (
      .clk(clk), .rst(rst), .start(start_v[3]), .busy(busy_v[3]), .done(done_v[3]), .err(err_v[3]),
`ifdef NTT_BITREV_CYCLE_CNT_EN
      .cycle_cnt(cc_v[3]),
`endif
      .BRAM_addr(addr_v[3]), .BRAM_clk(bclk_v[3]), .BRAM_din(din_v[3]), .BRAM_dout(dout_v[3]),
      .BRAM_en(en_v[3]), .BRAM_rst(brst_v[3]), .BRAM_we(we_v[3]));

   // ---------------- BRAM models (read-first, 1 or 2 cycle latency) ----------------
   logic [15:0] mem [4][32];
   logic [15:0] rd1 [4];
   logic [15:0] rd2 [4];
   int          acc [4] = '{0, 0, 0, 0};
   logic        ld_we = 1'b0;
   logic [4:0]  ld_addr = '0;
   logic [15:0] ld_data = '0;

   always @(posedge clk) begin
      for (int g = 0; g < 4; g++) begin
         rd2[g] <= rd1[g];
         if (ld_we) begin
            mem[g][ld_addr] <= ld_data;
         end else if (en_v[g]) begin
            acc[g] <= acc[g] + 1;
            rd1[g] <= mem[g][addr_v[g]];
            if (we_v[g]) mem[g][addr_v[g]] <= din_v[g];
         end
      end
   end

   assign dout_v[0] = rd1[0];
   assign dout_v[1] = rd1[1];
   assign dout_v[2] = rd2[2];
   assign dout_v[3] = rd1[3];

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_fail = 0;
   logic [15:0] perm8 [8] = '{16'd0, 16'd4, 16'd2, 16'd6, 16'd1, 16'd5, 16'd3, 16'd7};
   logic [15:0] part8 [8] = '{16'd0, 16'd4, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
   logic [15:0] fin8  [8] = '{16'd0, 16'd4, 16'd2, 16'd6, 16'd4, 16'd5, 16'd3, 16'd7};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic load_identity();
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         ld_we   = 1'b1;
         ld_addr = 5'(k);
         ld_data = 16'(k);
      end
      @(negedge clk);
      ld_we = 1'b0;
   endtask

   // Raise start in cycle 0 and optionally again in cycle 'poke'. Returns the
   // cycle done was seen (-1 when the bound runs out) and the busy cycle count.
   task automatic run(input int u, input int poke, output int done_cyc, output int busy_cnt);
      int cyc;
      cyc      = 0;
      busy_cnt = 0;
      done_cyc = -1;
      @(negedge clk);
      start_v[u] = 1'b1;
      while (cyc < 200) begin
         @(negedge clk);
         cyc++;
         start_v[u] = (cyc == poke);
         if (busy_v[u]) busy_cnt++;
         if (done_v[u]) begin
            done_cyc = cyc;
            break;
         end
      end
      @(negedge clk);
      start_v[u] = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int dc, bc, a0;
      rst     = 1'b0;
      start_v = '0;
      repeat (2) @(negedge clk);

      // Reset values
      for (int u = 0; u < 4; u++) begin
         chk($sformatf("rst_busy%0d", u), 32'(busy_v[u]), 0);
         chk($sformatf("rst_done%0d", u), 32'(done_v[u]), 0);
         chk($sformatf("rst_err%0d", u), 32'(err_v[u]), 0);
         chk($sformatf("rst_en%0d", u), 32'(en_v[u]), 0);
         chk($sformatf("rst_we%0d", u), 32'(we_v[u]), 0);
         chk($sformatf("rst_addr%0d", u), 32'(addr_v[u]), 0);
         chk($sformatf("rst_din%0d", u), 32'(din_v[u]), 0);
         chk($sformatf("rst_brst%0d", u), 32'(brst_v[u]), 1);
      end
      chk("bram_clk", 32'(bclk_v[0]), 32'(clk));
`ifdef NTT_BITREV_CYCLE_CNT_EN
      chk("rst_cnt", cc_v[0], 0);
`endif
      @(negedge clk);
      rst = 1'b1;
      load_identity();

      // Single batch, RD_LAT=1
      run(0, 0, dc, bc);
      chk("a_done_cyc", 32'(dc), 19);
      chk("a_busy_cnt", 32'(bc), 18);
      chk("a_done_pulse", 32'(done_v[0]), 0);
      for (int k = 0; k < 8; k++) chk($sformatf("a_mem%0d", k), 32'(mem[0][k]), 32'(perm8[k]));
      chk("a_mem8_untouched", 32'(mem[0][8]), 8);
`ifdef NTT_BITREV_CYCLE_CNT_EN
      chk("a_cycle_cnt", cc_v[0], 18);
`endif

      // Second run restores natural order
      run(0, 0, dc, bc);
      chk("a2_done_cyc", 32'(dc), 19);
      for (int k = 0; k < 8; k++) chk($sformatf("a2_mem%0d", k), 32'(mem[0][k]), 32'(k));

      // Two batches
      run(1, 0, dc, bc);
      chk("b_done_cyc", 32'(dc), 37);
      chk("b_busy_cnt", 32'(bc), 36);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("b_mem%0d", k), 32'(mem[1][k]), 32'(perm8[k]));
         chk($sformatf("b_mem%0d", k + 8), 32'(mem[1][k + 8]), 32'(perm8[k]) + 8);
      end
      for (int k = 16; k < 32; k++) chk($sformatf("b_mem%0d", k), 32'(mem[1][k]), 32'(k));

      // RD_LAT=2
      run(2, 0, dc, bc);
      chk("c_done_cyc", 32'(dc), 21);
      chk("c_busy_cnt", 32'(bc), 20);
      for (int k = 0; k < 8; k++) chk($sformatf("c_mem%0d", k), 32'(mem[2][k]), 32'(perm8[k]));

      // LOG_N=1: no pairs, no BRAM access
      a0 = acc[3];
      run(3, 0, dc, bc);
      chk("d_done_cyc", 32'(dc), 3);
      chk("d_busy_cnt", 32'(bc), 2);
      chk("d_no_access", 32'(acc[3] - a0), 0);
      chk("d_mem0", 32'(mem[3][0]), 0);
      chk("d_mem1", 32'(mem[3][1]), 1);

      // start while busy sets err; run is unaffected
      run(0, 5, dc, bc);
      chk("e_done_cyc", 32'(dc), 19);
      chk("e_err_set", 32'(err_v[0]), 1);
      for (int k = 0; k < 8; k++) chk($sformatf("e_mem%0d", k), 32'(mem[0][k]), 32'(perm8[k]));
      run(0, 0, dc, bc);
      chk("e2_err_clr", 32'(err_v[0]), 0);
      chk("e2_done_cyc", 32'(dc), 19);

      // start coinciding with done is ignored and sets err
      run(0, 19, dc, bc);
      chk("f_done_cyc", 32'(dc), 19);
      chk("f_busy_after", 32'(busy_v[0]), 0);
      chk("f_err_set", 32'(err_v[0]), 1);
      for (int k = 0; k < 8; k++) chk($sformatf("f_mem%0d", k), 32'(mem[0][k]), 32'(perm8[k]));

      // Reset in cycle 7 (WR_J of the first pair)
      load_identity();
      @(negedge clk);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (6) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("g_busy", 32'(busy_v[0]), 0);
      chk("g_done", 32'(done_v[0]), 0);
      chk("g_err", 32'(err_v[0]), 0);
      chk("g_en", 32'(en_v[0]), 0);
      chk("g_we", 32'(we_v[0]), 0);
      chk("g_addr", 32'(addr_v[0]), 0);
      chk("g_din", 32'(din_v[0]), 0);
      chk("g_brst", 32'(brst_v[0]), 1);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 8; k++) chk($sformatf("g_part%0d", k), 32'(mem[0][k]), 32'(part8[k]));
      run(0, 0, dc, bc);
      chk("h_done_cyc", 32'(dc), 19);
      chk("h_busy_cnt", 32'(bc), 18);
      for (int k = 0; k < 8; k++) chk($sformatf("h_mem%0d", k), 32'(mem[0][k]), 32'(fin8[k]));
`ifdef NTT_BITREV_CYCLE_CNT_EN
      chk("h_cycle_cnt", cc_v[0], 18);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
